refill_ctrl: RTL and testbench
==============================

Name: refill_ctrl

Overview:
- Miss/refill requester sitting between the I-cache, the D-cache and the 64-bit backing memory.
- Arbitrates the cache miss requests and drives the memory's imiss/dmiss/iaddr/daddr lines.
- Captures the 64-bit line returned with ifill/dfill and hands it back to the requesting cache with a one-cycle ack.
- Performs an optional single-beat dirty writeback (we/addr_in/data_in) before a D refill, and recovers from a lost fill via timeout.

Parameters:
TIMEOUT, 15, cycles to wait in a miss state for the matching fill before aborting (must be at least 4)
TO_W, 4, width of the timeout counter; TIMEOUT must be at most 2^TO_W-1
DRAIN, 4, cycles spent discarding late fills after a timeout

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ic_req  in  1  I-cache miss request, held until ic_ack
ic_addr  in  32  I-cache miss byte address
ic_ack  out  1  one-cycle pulse, ic_data valid
ic_data  out  64  refilled I line, held until next ic_ack
dc_req  in  1  D-cache miss request, held until dc_ack
dc_addr  in  32  D-cache miss byte address
dc_wb  in  1  dirty victim must be written before refill (qualified by dc_req)
dc_wb_addr  in  32  victim byte address
dc_wb_data  in  64  victim data
dc_ack  out  1  one-cycle pulse, dc_data valid
dc_data  out  64  refilled D line, held until next dc_ack
err  out  1  one-cycle pulse on timeout abort
mem_iaddr  out  32  to memory iaddr
mem_daddr  out  32  to memory daddr
mem_imiss  out  1  to memory imiss
mem_dmiss  out  1  to memory dmiss
mem_data  in  64  from memory data
mem_ifill  in  1  from memory ifill
mem_dfill  in  1  from memory dfill
mem_we  out  1  to memory we
mem_addr_in  out  32  to memory addr_in
mem_data_in  out  64  to memory data_in

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0.
- Addresses:
  - All memory addresses are driven 8-byte aligned, with bits [2:0] forced to 0.
  - mem_iaddr/mem_daddr are registered from the accepted request and held stable while the miss is asserted.
- Memory contract:
  - The memory accepts a miss only when it is idle, with D having priority over I.
  - The fill pulse is exactly 1 cycle, 3 cycles after the accepting edge, with mem_data valid in the same cycle.
  - The miss must drop on the edge at which the fill is sampled; otherwise the memory re-accepts it.
- States: IDLE, WB, DMISS, IMISS, DRAIN.
- IDLE transitions:
  - dc_req=1 and dc_wb=1 -> WB.
  - dc_req=1 and dc_wb=0 -> DMISS.
  - ic_req=1 only -> IMISS.
  - D wins when both requests are asserted.
- WB:
  - Drives mem_we=1 for exactly 1 cycle, with mem_addr_in = dc_wb_addr aligned and mem_data_in = dc_wb_data.
  - Next state is DMISS; the refill read is issued after the write has landed.
- DMISS:
  - mem_dmiss=1 and the counter increments each cycle.
  - On mem_dfill=1: register mem_data into dc_data, pulse dc_ack next cycle, drop mem_dmiss, go to IDLE.
- IMISS: symmetric to DMISS, using mem_imiss/mem_ifill/ic_data/ic_ack.
- Stray fills:
  - A fill of the wrong side, or any fill in IDLE/WB, is ignored: no ack, no data update.
  - A fill in DRAIN is discarded.
- Timeout:
  - When the counter reaches TIMEOUT in DMISS/IMISS: drop the miss, pulse err, go to DRAIN.
  - DRAIN lasts DRAIN cycles with fills discarded, then IDLE.
  - A still-held req is re-issued after DRAIN.
- Ack handshake:
  - Requesters drop req on the edge where they see ack.
  - The ack cycle is spent in IDLE, and IDLE ignores the requesting side's req during the ack cycle, so there is no double issue.
- Nominal latency: req seen in cycle 0 -> miss in cycle 1 -> fill in cycle 4 -> ack in cycle 5. With writeback, ack is in cycle 6.
- Reset mid-operation: all outputs clear asynchronously. A fill arriving later is ignored in IDLE.

Decomposition:
- Package refill_pkg holds:
  - the state enum (IDLE, WB, DMISS, IMISS, DRAIN);
  - LINE_W=64 and ADDR_W=32;
  - the alignment mask constant.
- One sub-module, refill_timer: loadable TO_W-bit counter with clear, enable and an expired flag. It is reused for both the TIMEOUT and DRAIN counts.

Test Plan:
- dc_req=1, dc_addr=0x40, dc_wb=0, memory holding 0x1122334455667788 at 0x40 -> mem_dmiss high in cycles 1-4, dc_ack in cycle 5, dc_data=0x1122334455667788, ic_ack never set.
- dc_req and ic_req both asserted, ic_addr=0x80 -> D serviced first with dc_ack in cycle 5; mem_imiss rises in cycle 6; ic_ack in cycle 10 with the line at 0x80.
- dc_req=1, dc_wb=1, dc_wb_addr=0x100, dc_wb_data=0xDEADBEEFCAFEF00D, dc_addr=0x100 -> mem_we for 1 cycle at addr 0x100; dc_ack in cycle 6 with dc_data=0xDEADBEEFCAFEF00D.
- ic_addr=0x47 (unaligned) -> mem_iaddr=0x40.
- Memory stub withholding fills, TIMEOUT=15 -> err pulse after 15 miss cycles, mem_imiss=0, no ack; then a late fill in DRAIN produces no ack; the request is re-issued after 4 cycles.
- rst_n pulsed low in cycle 2 of a DMISS -> all outputs 0 immediately; the fill in cycle 4 produces no dc_ack.

Source files
------------

// File: rtl/refill_pkg.sv
// Shared types and constants for the miss/refill requester.
package refill_pkg;

    localparam int LINE_W = 64;
    localparam int ADDR_W = 32;

    // Memory works on 8-byte lines, so the low three address bits are dropped.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'hFFFF_FFF8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WB    = 3'd1,
        ST_DMISS = 3'd2,
        ST_IMISS = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/refill_timer.sv
// Loadable up-counter with clear and enable; flags when the count equals term.
module refill_timer #(
    parameter int TO_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic [TO_W-1:0] load_val,
    input  logic            en,
    input  logic [TO_W-1:0] term,
    output logic            expired
);

    logic [TO_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + TO_W'(1);
        end
    end

    assign expired = (count_reg == term);

endmodule

// File: rtl/refill_ctrl.sv
// Arbitrates I/D cache misses onto the backing memory, with optional dirty
// writeback before a D refill and timeout recovery for lost fills.
module refill_ctrl
    import refill_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4,
    parameter int DRAIN   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_data,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_wb,
    input  logic [ADDR_W-1:0] dc_wb_addr,
    input  logic [LINE_W-1:0] dc_wb_data,
    output logic              dc_ack,
    output logic [LINE_W-1:0] dc_data,
    output logic              err,
    output logic [ADDR_W-1:0] mem_iaddr,
    output logic [ADDR_W-1:0] mem_daddr,
    output logic              mem_imiss,
    output logic              mem_dmiss,
    input  logic [LINE_W-1:0] mem_data,
    input  logic              mem_ifill,
    input  logic              mem_dfill,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr_in,
    output logic [LINE_W-1:0] mem_data_in
);

    localparam logic [TO_W-1:0] TMO_TERM   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] DRAIN_TERM = TO_W'(DRAIN);
    localparam logic [TO_W-1:0] TMR_ONE    = TO_W'(1);

    state_e state_reg, state_next;

    logic              ic_ack_reg, dc_ack_reg, err_reg;
    logic              mem_imiss_reg, mem_dmiss_reg, mem_we_reg;
    logic [LINE_W-1:0] ic_data_reg, dc_data_reg, mem_data_in_reg;
    logic [ADDR_W-1:0] mem_iaddr_reg, mem_daddr_reg, mem_addr_in_reg;

    logic              take_wb, take_d, take_i;
    logic              fill_d, fill_i, timeout;
    logic              tmr_clr, tmr_load, tmr_en, tmr_expired;
    logic [TO_W-1:0]   tmr_term;

    // One counter serves both the miss timeout and the post-timeout drain;
    // loading 1 on entry makes the count equal the number of cycles spent.
    refill_timer #(.TO_W(TO_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (TMR_ONE),
        .en       (tmr_en),
        .term     (tmr_term),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_next = state_reg;
        take_wb    = 1'b0;
        take_d     = 1'b0;
        take_i     = 1'b0;
        fill_d     = 1'b0;
        fill_i     = 1'b0;
        timeout    = 1'b0;
        tmr_clr    = 1'b0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        tmr_term   = TMO_TERM;
        case (state_reg)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                // The side being acked still holds req this cycle; skip it.
                if (dc_req && !dc_ack_reg) begin
                    tmr_load = 1'b1;
                    if (dc_wb) begin
                        take_wb    = 1'b1;
                        state_next = ST_WB;
                    end else begin
                        take_d     = 1'b1;
                        state_next = ST_DMISS;
                    end
                end else if (ic_req && !ic_ack_reg) begin
                    tmr_load   = 1'b1;
                    take_i     = 1'b1;
                    state_next = ST_IMISS;
                end
            end
            ST_WB: begin
                tmr_load   = 1'b1;
                take_d     = 1'b1;
                state_next = ST_DMISS;
            end
            ST_DMISS: begin
                tmr_en = 1'b1;
                if (mem_dfill) begin
                    fill_d     = 1'b1;
                    state_next = ST_IDLE;
                end else if (tmr_expired) begin
                    timeout    = 1'b1;
                    tmr_load   = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
            ST_IMISS: begin
                tmr_en = 1'b1;
                if (mem_ifill) begin
                    fill_i     = 1'b1;
                    state_next = ST_IDLE;
                end else if (tmr_expired) begin
                    timeout    = 1'b1;
                    tmr_load   = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                tmr_en   = 1'b1;
                tmr_term = DRAIN_TERM;
                if (tmr_expired) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            ic_ack_reg      <= 1'b0;
            dc_ack_reg      <= 1'b0;
            err_reg         <= 1'b0;
            mem_imiss_reg   <= 1'b0;
            mem_dmiss_reg   <= 1'b0;
            mem_we_reg      <= 1'b0;
            ic_data_reg     <= '0;
            dc_data_reg     <= '0;
            mem_data_in_reg <= '0;
            mem_iaddr_reg   <= '0;
            mem_daddr_reg   <= '0;
            mem_addr_in_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ic_ack_reg    <= fill_i;
            dc_ack_reg    <= fill_d;
            err_reg       <= timeout;
            // Miss lines follow the next state, so they drop on the fill edge.
            mem_imiss_reg <= (state_next == ST_IMISS);
            mem_dmiss_reg <= (state_next == ST_DMISS);
            mem_we_reg    <= take_wb;
            if (fill_i) begin
                ic_data_reg <= mem_data;
            end
            if (fill_d) begin
                dc_data_reg <= mem_data;
            end
            if (take_i) begin
                mem_iaddr_reg <= align_addr(ic_addr);
            end
            if (take_d) begin
                mem_daddr_reg <= align_addr(dc_addr);
            end
            if (take_wb) begin
                mem_addr_in_reg <= align_addr(dc_wb_addr);
                mem_data_in_reg <= dc_wb_data;
            end
        end
    end

    assign ic_ack      = ic_ack_reg;
    assign ic_data     = ic_data_reg;
    assign dc_ack      = dc_ack_reg;
    assign dc_data     = dc_data_reg;
    assign err         = err_reg;
    assign mem_iaddr   = mem_iaddr_reg;
    assign mem_daddr   = mem_daddr_reg;
    assign mem_imiss   = mem_imiss_reg;
    assign mem_dmiss   = mem_dmiss_reg;
    assign mem_we      = mem_we_reg;
    assign mem_addr_in = mem_addr_in_reg;
    assign mem_data_in = mem_data_in_reg;

endmodule

// File: tb/tb_refill_ctrl.sv
// Self-checking bench for refill_ctrl: memory stub, requesters and a
// transaction-level timing/data model driven by directed and random stimulus.
module tb_refill_ctrl;

    localparam int TIMEOUT = 15;
    localparam int TO_W    = 4;
    localparam int DRAIN   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req, dc_req, dc_wb;
    logic [31:0] ic_addr, dc_addr, dc_wb_addr;
    logic [63:0] dc_wb_data;
    logic        ic_ack, dc_ack, err;
    logic [63:0] ic_data, dc_data;
    logic [31:0] mem_iaddr, mem_daddr, mem_addr_in;
    logic        mem_imiss, mem_dmiss, mem_we;
    logic [63:0] mem_data, mem_data_in;
    logic        mem_ifill, mem_dfill;

    refill_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(TO_W), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_data(ic_data),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_wb(dc_wb), .dc_wb_addr(dc_wb_addr),
        .dc_wb_data(dc_wb_data), .dc_ack(dc_ack), .dc_data(dc_data), .err(err),
        .mem_iaddr(mem_iaddr), .mem_daddr(mem_daddr), .mem_imiss(mem_imiss),
        .mem_dmiss(mem_dmiss), .mem_data(mem_data), .mem_ifill(mem_ifill),
        .mem_dfill(mem_dfill), .mem_we(mem_we), .mem_addr_in(mem_addr_in),
        .mem_data_in(mem_data_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
    endtask

    // ---------------- memories (stub copy and reference copy) ----------------
    logic [63:0] stub_mem [logic [31:0]];
    logic [63:0] ref_mem  [logic [31:0]];

    function automatic logic [63:0] default_line(input logic [31:0] a);
        return {a ^ 32'hC3C3_0000, ~a};
    endfunction

    function automatic logic [63:0] stub_read(input logic [31:0] a);
        if (stub_mem.exists(a)) return stub_mem[a];
        return default_line(a);
    endfunction

    function automatic logic [63:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return default_line(a);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:3], 3'b000};
    endfunction

    task automatic preload(input logic [31:0] a, input logic [63:0] d);
        stub_mem[a] = d;
        ref_mem[a]  = d;
    endtask

    // ---------------- memory stub state ----------------
    bit          stub_pend = 0;
    bit          stub_side_d = 0;
    logic [31:0] stub_addr = '0;
    int          stub_fill_cyc = 0;
    bit          withhold = 0;
    bit          force_ifill = 0;
    bit          stray_en = 0;

    // ---------------- requester state ----------------
    bit          d_active = 0, d_drop = 0, d_wb_v = 0;
    logic [31:0] d_addr_v = '0, d_wb_addr_v = '0;
    logic [63:0] d_wb_data_v = '0;
    bit          i_active = 0, i_drop = 0;
    logic [31:0] i_addr_v = '0;

    // ---------------- reference model state ----------------
    int          busy_until = 0;
    int          d_ack_at = -1, i_ack_at = -1, err_at = -1;
    logic [63:0] d_exp = '0, i_exp = '0;

    task automatic model_reset();
        busy_until = cyc + 1;
        d_ack_at   = -1;
        i_ack_at   = -1;
        err_at     = -1;
    endtask

    task automatic model_check();
        check("dc_ack", 64'(dc_ack), 64'(cyc == d_ack_at));
        if (cyc == d_ack_at) check("dc_data", dc_data, d_exp);
        check("ic_ack", 64'(ic_ack), 64'(cyc == i_ack_at));
        if (cyc == i_ack_at) check("ic_data", ic_data, i_exp);
        check("err", 64'(err), 64'(cyc == err_at));
    endtask

    // Transaction view: when the controller is free and a request is visible,
    // the miss starts next cycle (one later with writeback), the fill lands
    // three cycles into the miss and the ack follows; a lost fill instead
    // yields err after TIMEOUT miss cycles and DRAIN cycles of dead time.
    task automatic model_step();
        int ms;
        if (cyc >= busy_until) begin
            if (dc_req && cyc != d_ack_at) begin
                ms = cyc + 1 + (dc_wb ? 1 : 0);
                if (dc_wb) ref_mem[line_of(dc_wb_addr)] = dc_wb_data;
                d_exp = ref_read(line_of(dc_addr));
                if (withhold) begin
                    err_at     = ms + TIMEOUT;
                    busy_until = err_at + DRAIN;
                end else begin
                    d_ack_at   = ms + 4;
                    busy_until = d_ack_at;
                end
            end else if (ic_req && cyc != i_ack_at) begin
                ms = cyc + 1;
                i_exp = ref_read(line_of(ic_addr));
                if (withhold) begin
                    err_at     = ms + TIMEOUT;
                    busy_until = err_at + DRAIN;
                end else begin
                    i_ack_at   = ms + 4;
                    busy_until = i_ack_at;
                end
            end
        end
    endtask

    task automatic stub_step();
        bit filling;
        filling   = 0;
        mem_dfill = 1'b0;
        mem_ifill = 1'b0;
        if (mem_we) stub_mem[mem_addr_in] = mem_data_in;
        if (stub_pend && cyc == stub_fill_cyc) begin
            stub_pend = 0;
            filling   = 1;
            if (!withhold) begin
                mem_data = stub_read(stub_addr);
                if (stub_side_d) mem_dfill = 1'b1;
                else             mem_ifill = 1'b1;
            end
        end else if (!stub_pend && (mem_dmiss || mem_imiss)) begin
            stub_pend     = 1;
            stub_side_d   = mem_dmiss;
            stub_addr     = mem_dmiss ? mem_daddr : mem_iaddr;
            stub_fill_cyc = cyc + 3;
        end
        if (force_ifill) begin
            mem_ifill = 1'b1;
            mem_data  = {$urandom, $urandom};
        end else if (stray_en && !filling && $urandom_range(7) == 0) begin
            mem_data = {$urandom, $urandom};
            if (stub_pend) begin
                if (stub_side_d) mem_ifill = 1'b1;
                else             mem_dfill = 1'b1;
            end else if ($urandom_range(1) == 0) begin
                mem_ifill = 1'b1;
            end else begin
                mem_dfill = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        model_check();
        if (d_drop) begin
            d_active = 0;
            d_drop   = 0;
        end else if (d_active && dc_ack) begin
            d_drop = 1;
        end
        if (i_drop) begin
            i_active = 0;
            i_drop   = 0;
        end else if (i_active && ic_ack) begin
            i_drop = 1;
        end
        dc_req     = d_active;
        dc_addr    = d_addr_v;
        dc_wb      = d_wb_v;
        dc_wb_addr = d_wb_addr_v;
        dc_wb_data = d_wb_data_v;
        ic_req     = i_active;
        ic_addr    = i_addr_v;
        stub_step();
        model_step();
    endtask

    task automatic issue_d(input logic [31:0] a, input bit wb, input logic [31:0] wa,
                           input logic [63:0] wd);
        d_active    = 1;
        d_addr_v    = a;
        d_wb_v      = wb;
        d_wb_addr_v = wa;
        d_wb_data_v = wd;
    endtask

    task automatic issue_i(input logic [31:0] a);
        i_active = 1;
        i_addr_v = a;
    endtask

    int t0;

    initial begin
        rst_n = 1'b0;
        ic_req = 0; dc_req = 0; dc_wb = 0;
        ic_addr = '0; dc_addr = '0; dc_wb_addr = '0; dc_wb_data = '0;
        mem_data = '0; mem_ifill = 0; mem_dfill = 0;
        repeat (2) @(negedge clk);
        check("rst_imiss", 64'(mem_imiss), 64'd0);
        check("rst_dmiss", 64'(mem_dmiss), 64'd0);
        check("rst_we",    64'(mem_we), 64'd0);
        check("rst_err",   64'(err), 64'd0);
        check("rst_daddr", 64'(mem_daddr), 64'd0);
        check("rst_dc_data", dc_data, 64'd0);
        rst_n = 1'b1;

        // D miss without writeback
        preload(32'h40, 64'h1122334455667788);
        issue_d(32'h40, 0, 32'h0, 64'h0);
        for (int k = 0; k <= 7; k++) begin
            step();
            check("t1_dmiss", 64'(mem_dmiss), 64'(k >= 1 && k <= 4));
            if (k == 5) check("t1_dc_data", dc_data, 64'h1122334455667788);
        end

        // simultaneous requests: D first, then I
        preload(32'h80, 64'h0123456789ABCDEF);
        issue_d(32'h48, 0, 32'h0, 64'h0);
        issue_i(32'h80);
        for (int k = 0; k <= 11; k++) begin
            step();
            check("t2_dc_ack", 64'(dc_ack), 64'(k == 5));
            check("t2_imiss", 64'(mem_imiss), 64'(k >= 6 && k <= 9));
            check("t2_ic_ack", 64'(ic_ack), 64'(k == 10));
            if (k == 10) check("t2_ic_data", ic_data, 64'h0123456789ABCDEF);
        end

        // dirty writeback ahead of the refill
        issue_d(32'h100, 1, 32'h100, 64'hDEADBEEFCAFEF00D);
        for (int k = 0; k <= 7; k++) begin
            step();
            check("t3_we", 64'(mem_we), 64'(k == 1));
            if (k == 1) begin
                check("t3_addr_in", 64'(mem_addr_in), 64'h100);
                check("t3_data_in", mem_data_in, 64'hDEADBEEFCAFEF00D);
            end
            check("t3_dc_ack", 64'(dc_ack), 64'(k == 6));
            if (k == 6) check("t3_dc_data", dc_data, 64'hDEADBEEFCAFEF00D);
        end

        // unaligned I address
        issue_i(32'h47);
        for (int k = 0; k <= 7; k++) begin
            step();
            if (k == 1) check("t4_iaddr", 64'(mem_iaddr), 64'h40);
            if (k == 5) check("t4_ic_data", ic_data, 64'h1122334455667788);
        end

        // lost fill: timeout, drain with a late fill, then re-issue
        withhold = 1;
        issue_i(32'h200);
        for (int k = 0; k <= 27; k++) begin
            force_ifill = (k == 17);
            if (k == 18) withhold = 0;
            step();
            if (k <= 21) check("t5_imiss", 64'(mem_imiss), 64'(k >= 1 && k <= 15 || k == 21));
            if (k == 16) check("t5_err", 64'(err), 64'd1);
            if (k == 18) check("t5_late_ack", 64'(ic_ack), 64'd0);
            if (k == 25) check("t5_ic_ack", 64'(ic_ack), 64'd1);
        end
        force_ifill = 0;

        // reset during a D miss; the stub's fill afterwards must be ignored
        issue_d(32'h300, 0, 32'h0, 64'h0);
        for (int k = 0; k <= 2; k++) step();
        rst_n = 1'b0;
        #1;
        check("t6_dmiss", 64'(mem_dmiss), 64'd0);
        check("t6_daddr", 64'(mem_daddr), 64'd0);
        check("t6_dc_data", dc_data, 64'd0);
        check("t6_ic_data", ic_data, 64'd0);
        check("t6_iaddr", 64'(mem_iaddr), 64'd0);
        model_reset();
        d_active = 0; d_drop = 0; dc_req = 0;
        step();
        rst_n = 1'b1;
        step();
        check("t6_fill_seen", 64'(mem_dfill), 64'd1);
        step();
        check("t6_no_ack", 64'(dc_ack), 64'd0);
        check("t6_data_kept", dc_data, 64'd0);

        // randomized traffic with stray fills
        stray_en = 1;
        for (int n = 0; n < 2500; n++) begin
            if (!d_active && !d_drop && $urandom_range(3) == 0)
                issue_d($urandom_range(32'hFFF), $urandom_range(2) == 0,
                        ($urandom_range(1) == 0) ? d_addr_v : $urandom_range(32'hFFF),
                        {$urandom, $urandom});
            if (!i_active && !i_drop && $urandom_range(3) == 0)
                issue_i($urandom_range(32'hFFF));
            step();
        end
        stray_en = 0;
        repeat (40) step();
        check("end_d_idle", 64'(d_active), 64'd0);
        check("end_i_idle", 64'(i_active), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
